map_table: RTL and testbench

- Register-rename map table for the P6-style out-of-order core, one stage upstream of the reservation station (RS).
- Holds, per architectural register, the ROB tag of its latest in-flight producer and a "value complete in ROB" bit (T+).
- At dispatch it produces the MT2RS_PACKET (rs1/rs2 tag plus ready) consumed by RS entries, then renames the destination.
- Snoops the CDB to set ready bits, clears mappings on ROB retire, and clears everything on squash.

---
 rtl/map_table_pkg.sv | 32 +++
 rtl/map_table_entry.sv | 34 +++
 rtl/map_table.sv | 69 ++++++
 tb/tb_map_table.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/map_table_pkg.sv
// Shared rename definitions: ROB tag width, CDB and map-table-to-RS bundles.
package map_table_pkg;

    localparam int NUM_ARCH_REG = 32;
    localparam int ROB_SZ       = 32;
    localparam int ROB_IDX_W    = $clog2(ROB_SZ);
    localparam int ARCH_IDX_W   = $clog2(NUM_ARCH_REG);
    localparam int XLEN         = 32;

    typedef logic [ROB_IDX_W-1:0]  rob_tag_t;
    typedef logic [ARCH_IDX_W-1:0] arch_idx_t;

    localparam rob_tag_t ZERO_TAG = '0;

    typedef struct packed {
        rob_tag_t        reg_tag;
        logic [XLEN-1:0] reg_value;
    } CDB_PACKET;

    typedef struct packed {
        rob_tag_t rs1_tag;
        rob_tag_t rs2_tag;
        logic     rs1_ready;
        logic     rs2_ready;
    } MT2RS_PACKET;

    // Tag 0 means "in register file" and can never match a broadcast.
    function automatic logic tag_hit(rob_tag_t held, rob_tag_t bcast);
        return (held != ZERO_TAG) && (held == bcast);
    endfunction

endpackage

// File: rtl/map_table_entry.sv
// One architectural register's rename state: producer ROB tag plus T+ bit.
module map_table_entry
    import map_table_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 squash,
    input  logic                 dispatch_hit,
    input  logic [ROB_IDX_W-1:0] dest_tag,
    input  logic                 retire_hit,
    input  logic [ROB_IDX_W-1:0] cdb_tag,
    output logic [ROB_IDX_W-1:0] tag,
    output logic                 rdy
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag <= ZERO_TAG;
            rdy <= 1'b0;
        end else if (squash) begin
            tag <= ZERO_TAG;
            rdy <= 1'b0;
        end else if (dispatch_hit) begin
            tag <= dest_tag;
            rdy <= 1'b0;
        end else if (retire_hit) begin
            tag <= ZERO_TAG;
            rdy <= 1'b0;
        end else if (tag_hit(tag, cdb_tag)) begin
            rdy <= 1'b1;
        end
    end

endmodule

// File: rtl/map_table.sv
// Register-rename map table: source lookup with CDB forwarding, dest rename,
// retire clear and squash flush.
module map_table
    import map_table_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dispatch_en,
    input  logic [4:0]           rs1_idx,
    input  logic [4:0]           rs2_idx,
    input  logic [4:0]           dest_idx,
    input  logic [ROB_IDX_W-1:0] dest_tag,
    input  CDB_PACKET            cdb_packet_in,
    input  logic                 retire_en,
    input  logic [4:0]           retire_idx,
    input  logic [ROB_IDX_W-1:0] retire_tag,
    input  logic                 squash,
    output MT2RS_PACKET          mt2rs_packet_out
);

    rob_tag_t tags [NUM_ARCH_REG];
    logic     rdys [NUM_ARCH_REG];

    // The value field only matters to the RS; the map table watches tags.
    logic cdb_value_unused;
    assign cdb_value_unused = ^cdb_packet_in.reg_value;

    assign tags[0] = ZERO_TAG;
    assign rdys[0] = 1'b0;

    for (genvar r = 1; r < NUM_ARCH_REG; r++) begin : g_entry
        logic dispatch_hit;
        logic retire_hit;

        assign dispatch_hit = dispatch_en
                            && (dest_idx == arch_idx_t'(r));
        assign retire_hit   = retire_en
                            && (retire_idx == arch_idx_t'(r))
                            && (tags[r] == retire_tag);

        map_table_entry u_entry (
            .clock        (clock),
            .reset        (reset),
            .squash       (squash),
            .dispatch_hit (dispatch_hit),
            .dest_tag     (dest_tag),
            .retire_hit   (retire_hit),
            .cdb_tag      (cdb_packet_in.reg_tag),
            .tag          (tags[r]),
            .rdy          (rdys[r])
        );
    end

    // Reads pre-update state, so a source equal to dest sees the old mapping.
    always_comb begin
        mt2rs_packet_out = '0;
        if (rs1_idx != '0) begin
            mt2rs_packet_out.rs1_tag   = tags[rs1_idx];
            mt2rs_packet_out.rs1_ready = rdys[rs1_idx]
                | tag_hit(tags[rs1_idx], cdb_packet_in.reg_tag);
        end
        if (rs2_idx != '0) begin
            mt2rs_packet_out.rs2_tag   = tags[rs2_idx];
            mt2rs_packet_out.rs2_ready = rdys[rs2_idx]
                | tag_hit(tags[rs2_idx], cdb_packet_in.reg_tag);
        end
    end

endmodule

// File: tb/tb_map_table.sv
// Randomized scoreboard bench for map_table against an array reference model.
module tb_map_table;
    import map_table_pkg::*;

    logic        clock;
    logic        reset;
    logic        dispatch_en;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [4:0]  dest_idx;
    rob_tag_t    dest_tag;
    CDB_PACKET   cdb_packet_in;
    logic        retire_en;
    logic [4:0]  retire_idx;
    rob_tag_t    retire_tag;
    logic        squash;
    MT2RS_PACKET mt2rs_packet_out;

    map_table dut (
        .clock            (clock),
        .reset            (reset),
        .dispatch_en      (dispatch_en),
        .rs1_idx          (rs1_idx),
        .rs2_idx          (rs2_idx),
        .dest_idx         (dest_idx),
        .dest_tag         (dest_tag),
        .cdb_packet_in    (cdb_packet_in),
        .retire_en        (retire_en),
        .retire_idx       (retire_idx),
        .retire_tag       (retire_tag),
        .squash           (squash),
        .mt2rs_packet_out (mt2rs_packet_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        check;
        MT2RS_PACKET pkt;
        int          cyc;
    } exp_t;

    exp_t     sb [$];
    int       n_checks = 0;
    int       n_fail   = 0;
    int       cyc      = 0;
    rob_tag_t m_tag [32];
    logic     m_rdy [32];

    function automatic MT2RS_PACKET predict(logic [4:0] a, logic [4:0] b,
                                            rob_tag_t ct);
        MT2RS_PACKET p;
        p = '0;
        if (a != 0) begin
            p.rs1_tag   = m_tag[a];
            p.rs1_ready = m_rdy[a] || (m_tag[a] != 0 && m_tag[a] == ct);
        end
        if (b != 0) begin
            p.rs2_tag   = m_tag[b];
            p.rs2_ready = m_rdy[b] || (m_tag[b] != 0 && m_tag[b] == ct);
        end
        return p;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            m_tag[r] = '0;
            m_rdy[r] = 1'b0;
        end
    endtask

    task automatic step(input logic de, input logic [4:0] r1,
                        input logic [4:0] r2, input logic [4:0] d,
                        input rob_tag_t dt, input rob_tag_t ct,
                        input logic re, input logic [4:0] ri,
                        input rob_tag_t rt, input logic sq);
        exp_t     e;
        rob_tag_t nt [32];
        logic     nr [32];
        @(negedge clock);
        dispatch_en           = de;
        rs1_idx               = r1;
        rs2_idx               = r2;
        dest_idx              = d;
        dest_tag              = dt;
        cdb_packet_in.reg_tag = ct;
        cdb_packet_in.reg_value = $urandom;
        retire_en             = re;
        retire_idx            = ri;
        retire_tag            = rt;
        squash                = sq;
        e.check = !sq;
        e.pkt   = predict(r1, r2, ct);
        e.cyc   = cyc;
        sb.push_back(e);
        @(posedge clock);
        cyc++;
        // Apply effects lowest priority first so later rules overwrite.
        for (int r = 0; r < 32; r++) begin
            nt[r] = m_tag[r];
            nr[r] = m_rdy[r];
            if (ct != 0 && m_tag[r] == ct) nr[r] = 1'b1;
        end
        if (re && ri != 0 && m_tag[ri] == rt) begin
            nt[ri] = '0;
            nr[ri] = 1'b0;
        end
        if (de && d != 0) begin
            nt[d] = dt;
            nr[d] = 1'b0;
        end
        for (int r = 0; r < 32; r++) begin
            m_tag[r] = sq ? '0 : nt[r];
            m_rdy[r] = sq ? 1'b0 : nr[r];
        end
    endtask

    task automatic look(input logic [4:0] a, input logic [4:0] b);
        step(0, a, b, 0, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic direct_zero_check(input string name);
        n_checks++;
        if (mt2rs_packet_out !== '0) begin
            n_fail++;
            $display("FAIL %s: got %h expected 0", name, mt2rs_packet_out);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clock);
        dispatch_en = 0;
        retire_en   = 0;
        squash      = 0;
        cdb_packet_in = '0;
        rs1_idx = 5'($urandom_range(1, 31));
        rs2_idx = 5'($urandom_range(1, 31));
        #2;
        reset = 1'b0;
        #1;
        direct_zero_check("async_reset");
        model_clear();
        #1;
        reset = 1'b1;
    endtask

    always begin : monitor
        exp_t e;
        @(negedge clock);
        #2;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.check) begin
                n_checks++;
                if (mt2rs_packet_out !== e.pkt) begin
                    n_fail++;
                    $display("FAIL lookup cyc %0d: got %h expected %h",
                             e.cyc, mt2rs_packet_out, e.pkt);
                end
            end
        end
    end

    initial begin : stimulus
        logic [4:0] ri;
        rob_tag_t   ct;
        rob_tag_t   rt;
        int         pick;
        reset = 1'b0;
        dispatch_en = 0; rs1_idx = 5; rs2_idx = 6; dest_idx = 0;
        dest_tag = 1; cdb_packet_in = '0; retire_en = 0;
        retire_idx = 0; retire_tag = 0; squash = 0;
        model_clear();
        repeat (2) @(posedge clock);
        #2;
        direct_zero_check("in_reset");
        @(negedge clock);
        reset = 1'b1;

        // Plan 1: cold lookup, then rename r5
        look(5, 6);
        step(1, 0, 0, 5, 3, 0, 0, 0, 0, 0);
        look(5, 6);
        // Plan 2: CDB forwarding and T+ capture
        step(0, 5, 0, 0, 1, 3, 0, 0, 0, 0);
        look(5, 0);
        step(0, 5, 5, 0, 1, 4, 0, 0, 0, 0);
        look(5, 0);
        // Plan 3: stale retire ignored, matching retire clears
        step(1, 0, 0, 7, 9, 0, 0, 0, 0, 0);
        step(1, 7, 0, 7, 10, 0, 0, 0, 0, 0);
        step(0, 7, 0, 0, 1, 0, 1, 7, 9, 0);
        look(7, 0);
        step(0, 7, 0, 0, 1, 0, 1, 7, 10, 0);
        look(7, 5);
        // Plan 4: dispatch beats retire and CDB on same register
        step(1, 0, 0, 8, 11, 0, 0, 0, 0, 0);
        step(1, 8, 8, 8, 12, 11, 1, 8, 11, 0);
        look(8, 0);
        // Plan 5: source equal to dest, register 0 stays unmapped
        step(1, 0, 0, 2, 4, 0, 0, 0, 0, 0);
        step(1, 2, 0, 2, 5, 0, 0, 0, 0, 0);
        step(1, 0, 2, 0, 6, 0, 0, 0, 0, 0);
        look(0, 2);
        // Plan 6: squash with dispatch, then async reset
        step(1, 0, 0, 10, 13, 0, 0, 0, 0, 0);
        step(1, 5, 9, 9, 7, 0, 0, 0, 0, 1);
        look(5, 8);
        look(9, 10);
        step(1, 0, 0, 11, 14, 0, 0, 0, 0, 0);
        step(0, 11, 0, 0, 1, 14, 0, 0, 0, 0);
        reset_pulse();
        look(11, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                reset_pulse();
                continue;
            end
            pick = $urandom_range(0, 3);
            ct = (pick < 2) ? m_tag[$urandom_range(0, 31)]
                            : rob_tag_t'($urandom_range(0, 31));
            ri = 5'($urandom_range(0, 31));
            rt = ($urandom_range(0, 9) < 7) ? m_tag[ri]
                                            : rob_tag_t'($urandom_range(0, 31));
            step(1'($urandom_range(0, 2) != 0),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 5'($urandom_range(0, 31)),
                 rob_tag_t'($urandom_range(1, 31)), ct,
                 1'($urandom_range(0, 1)), ri, rt,
                 1'($urandom_range(0, 63) == 0));
        end

        @(negedge clock);
        #4;
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
